// File: rtl/program_loader_if.sv
// Boot loader port bundle: byte stream in, instruction/data BRAM write ports and
// CPU hand-off status out.
interface program_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  start;
    logic [7:0]            s_dat;
    logic                  s_valid;
    logic                  s_ready;

    logic [ADDR_WIDTH-1:0] i_w_addr;
    logic [31:0]           i_w_dat;
    logic                  i_w_enb;

    logic [ADDR_WIDTH-1:0] d_w_addr;
    logic [31:0]           d_w_dat;
    logic                  d_w_enb;

    logic                  pc_stall;
    logic                  d_bram_init_done;
    logic                  busy;
    logic                  err;

    // Host / stream source side
    modport master (
        output start, s_dat, s_valid,
        input  s_ready,
        input  i_w_addr, i_w_dat, i_w_enb,
        input  d_w_addr, d_w_dat, d_w_enb,
        input  pc_stall, d_bram_init_done, busy, err
    );

    // Loader side
    modport slave (
        input  start, s_dat, s_valid,
        output s_ready,
        output i_w_addr, i_w_dat, i_w_enb,
        output d_w_addr, d_w_dat, d_w_enb,
        output pc_stall, d_bram_init_done, busy, err
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit words and
// writes them to instruction and data BRAM, holding the CPU PC until the image is loaded.
module program_loader #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned MAX_I_WORDS = 256,
    parameter int unsigned MAX_D_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);

    localparam int unsigned MAX_WORDS = (MAX_I_WORDS > MAX_D_WORDS) ? MAX_I_WORDS : MAX_D_WORDS;
    localparam int unsigned IDX_W     = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_I  = 3'd1,
        HDR_D  = 3'd2,
        LOAD_I = 3'd3,
        LOAD_D = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_buf;
    logic [31:0]           n_i;
    logic [31:0]           n_d;
    logic [IDX_W-1:0]      word_idx;

    logic                  s_ready_r;
    logic [ADDR_WIDTH-1:0] i_w_addr_r;
    logic [31:0]           i_w_dat_r;
    logic                  i_w_enb_r;
    logic [ADDR_WIDTH-1:0] d_w_addr_r;
    logic [31:0]           d_w_dat_r;
    logic                  d_w_enb_r;
    logic                  pc_stall_r;
    logic                  init_done_r;
    logic                  busy_r;
    logic                  err_r;

    logic                  accept;
    logic                  word_done;
    logic [31:0]           word_full;
    logic [31:0]           idx_next;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  hdr_bad;

    // The 4th byte of a word completes it combinationally with the three buffered bytes
    assign accept    = bus.s_valid & s_ready_r;
    assign word_done = accept & (byte_cnt == 2'd3);
    assign word_full = {bus.s_dat, word_buf};
    assign idx_next  = 32'(word_idx) + 32'd1;
    assign word_addr = ADDR_WIDTH'({word_idx, 2'b00});
    assign hdr_bad   = (n_i > 32'(MAX_I_WORDS)) | (word_full > 32'(MAX_D_WORDS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            word_buf    <= 24'd0;
            n_i         <= 32'd0;
            n_d         <= 32'd0;
            word_idx    <= '0;
            s_ready_r   <= 1'b0;
            i_w_addr_r  <= '0;
            i_w_dat_r   <= 32'd0;
            i_w_enb_r   <= 1'b0;
            d_w_addr_r  <= '0;
            d_w_dat_r   <= 32'd0;
            d_w_enb_r   <= 1'b0;
            pc_stall_r  <= 1'b1;
            init_done_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            i_w_enb_r <= 1'b0;
            d_w_enb_r <= 1'b0;

            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word_buf[7:0]   <= bus.s_dat;
                    2'd1:    word_buf[15:8]  <= bus.s_dat;
                    2'd2:    word_buf[23:16] <= bus.s_dat;
                    default: word_buf        <= word_buf;
                endcase
            end

            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start) begin
                        state       <= HDR_I;
                        byte_cnt    <= 2'd0;
                        s_ready_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        err_r       <= 1'b0;
                        pc_stall_r  <= 1'b1;
                        init_done_r <= 1'b0;
                    end else if (state == DONE) begin
                        // Released one cycle after entry so the final write pulse lands first
                        pc_stall_r  <= 1'b0;
                        init_done_r <= 1'b1;
                    end
                end

                HDR_I: begin
                    if (word_done) begin
                        n_i   <= word_full;
                        state <= HDR_D;
                    end
                end

                HDR_D: begin
                    if (word_done) begin
                        n_d      <= word_full;
                        word_idx <= '0;
                        if (hdr_bad) begin
                            state     <= ERROR;
                            err_r     <= 1'b1;
                            s_ready_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end else if (n_i != 32'd0) begin
                            state <= LOAD_I;
                        end else if (word_full != 32'd0) begin
                            state <= LOAD_D;
                        end else begin
                            state     <= DONE;
                            s_ready_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end
                    end
                end

                LOAD_I: begin
                    if (word_done) begin
                        i_w_enb_r  <= 1'b1;
                        i_w_addr_r <= word_addr;
                        i_w_dat_r  <= word_full;
                        word_idx   <= word_idx + IDX_W'(1);
                        if (idx_next == n_i) begin
                            word_idx <= '0;
                            if (n_d != 32'd0) begin
                                state <= LOAD_D;
                            end else begin
                                state     <= DONE;
                                s_ready_r <= 1'b0;
                                busy_r    <= 1'b0;
                            end
                        end
                    end
                end

                LOAD_D: begin
                    if (word_done) begin
                        d_w_enb_r  <= 1'b1;
                        d_w_addr_r <= word_addr;
                        d_w_dat_r  <= word_full;
                        word_idx   <= word_idx + IDX_W'(1);
                        if (idx_next == n_d) begin
                            word_idx  <= '0;
                            state     <= DONE;
                            s_ready_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    s_ready_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready          = s_ready_r;
    assign bus.i_w_addr         = i_w_addr_r;
    assign bus.i_w_dat          = i_w_dat_r;
    assign bus.i_w_enb          = i_w_enb_r;
    assign bus.d_w_addr         = d_w_addr_r;
    assign bus.d_w_dat          = d_w_dat_r;
    assign bus.d_w_enb          = d_w_enb_r;
    assign bus.pc_stall         = pc_stall_r;
    assign bus.d_bram_init_done = init_done_r;
    assign bus.busy             = busy_r;
    assign bus.err              = err_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: random byte-stream sessions against a
// word-level reference, with a queue scoreboard checking every BRAM write cycle-exactly.
module tb_program_loader;

    localparam int unsigned AW    = 10;
    localparam int unsigned MAX_W = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    program_loader #(
        .ADDR_WIDTH (AW),
        .MAX_I_WORDS(MAX_W),
        .MAX_D_WORDS(MAX_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   dat;
        int            cyc;
    } wr_t;

    typedef struct {
        bit            is_d;
        logic [AW-1:0] addr;
        logic [31:0]   dat;
    } plan_t;

    wr_t         exp_i[$];
    wr_t         exp_d[$];
    logic [31:0] iw[$];
    logic [31:0] dw[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the next expected write and its cycle
    always @(negedge clk) begin
        wr_t e;
        if (bus.i_w_enb) begin
            if (exp_i.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL i_w_unexpected: pulse addr 0x%0h dat 0x%08h, none expected (cycle %0d)",
                         bus.i_w_addr, bus.i_w_dat, cyc);
            end else begin
                e = exp_i.pop_front();
                chk("i_w_addr", 32'(bus.i_w_addr), 32'(e.addr));
                chk("i_w_dat", bus.i_w_dat, e.dat);
                chk("i_w_cycle", cyc, e.cyc);
            end
        end
        if (bus.d_w_enb) begin
            if (exp_d.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d_w_unexpected: pulse addr 0x%0h dat 0x%08h, none expected (cycle %0d)",
                         bus.d_w_addr, bus.d_w_dat, cyc);
            end else begin
                e = exp_d.pop_front();
                chk("d_w_addr", 32'(bus.d_w_addr), 32'(e.addr));
                chk("d_w_dat", bus.d_w_dat, e.dat);
                chk("d_w_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_s_ready", 32'(bus.s_ready), 0);
        chk("rst_i_w_enb", 32'(bus.i_w_enb), 0);
        chk("rst_d_w_enb", 32'(bus.d_w_enb), 0);
        chk("rst_i_w_addr", 32'(bus.i_w_addr), 0);
        chk("rst_d_w_addr", 32'(bus.d_w_addr), 0);
        chk("rst_i_w_dat", bus.i_w_dat, 0);
        chk("rst_d_w_dat", bus.d_w_dat, 0);
        chk("rst_pc_stall", 32'(bus.pc_stall), 1);
        chk("rst_init_done", 32'(bus.d_bram_init_done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err), 0);
    endtask

    // Called just after a posedge; returns just after a posedge
    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start_s_ready", 32'(bus.s_ready), 1);
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_err", 32'(bus.err), 0);
        chk("start_pc_stall", 32'(bus.pc_stall), 1);
        chk("start_init_done", 32'(bus.d_bram_init_done), 0);
        @(posedge clk); #1;
    endtask

    // Offers one byte until accepted; acc_cyc is the cycle right after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit with_start, output int acc_cyc, output bit ok);
        logic r;
        int   budget;
        budget      = 0;
        ok          = 1'b0;
        bus.s_dat   = b;
        bus.s_valid = 1'b1;
        bus.start   = with_start;
        while (!ok && budget < 40) begin
            @(negedge clk);
            r = bus.s_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (r) ok = 1'b1;
            budget++;
        end
        bus.s_valid = 1'b0;
        acc_cyc     = cyc;
    endtask

    // One load session from the header counts and iw/dw payload queues
    task automatic run_session(input logic [31:0] ni, input logic [31:0] nd, input int gap_max,
                               input int start_at, input int stop_after);
        logic [7:0] bytes[$];
        plan_t      plan[$];
        plan_t      p;
        wr_t        w;
        bit         legal;
        bit         ok;
        int         acc;
        int         g;

        legal = (ni <= 32'(MAX_W)) && (nd <= 32'(MAX_W));
        for (int k = 0; k < 4; k++) bytes.push_back(8'(ni >> (8 * k)));
        for (int k = 0; k < 4; k++) bytes.push_back(8'(nd >> (8 * k)));
        if (legal) begin
            for (int k = 0; k < int'(ni); k++) begin
                for (int b = 0; b < 4; b++) bytes.push_back(8'(iw[k] >> (8 * b)));
                plan.push_back('{1'b0, AW'(k * 4), iw[k]});
            end
            for (int k = 0; k < int'(nd); k++) begin
                for (int b = 0; b < 4; b++) bytes.push_back(8'(dw[k] >> (8 * b)));
                plan.push_back('{1'b1, AW'(k * 4), dw[k]});
            end
        end

        pulse_start();
        for (int j = 0; j < bytes.size(); j++) begin
            if (stop_after >= 0 && j >= stop_after) break;
            if (gap_max > 0) begin
                g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    bus.s_dat = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            send_byte(bytes[j], j == start_at, acc, ok);
            if (!ok) begin
                chk("accept_timeout", 32'(j), 32'hFFFF_FFFF);
                return;
            end
            if (j >= 8 && ((j - 8) % 4) == 3) begin
                p = plan.pop_front();
                w = '{p.addr, p.dat, acc};
                if (p.is_d) exp_d.push_back(w);
                else        exp_i.push_back(w);
            end
        end
        if (stop_after >= 0) return;

        // Cycle of the final accept's aftermath: stream closed, PC still held
        @(negedge clk);
        chk("end_s_ready", 32'(bus.s_ready), 0);
        chk("end_busy", 32'(bus.busy), 0);
        chk("end_pc_stall_hold", 32'(bus.pc_stall), 1);
        chk("end_err", 32'(bus.err), legal ? 0 : 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("final_pc_stall", 32'(bus.pc_stall), legal ? 0 : 1);
        chk("final_init_done", 32'(bus.d_bram_init_done), legal ? 1 : 0);
        chk("final_s_ready", 32'(bus.s_ready), 0);
        chk("final_err", 32'(bus.err), legal ? 0 : 1);
        chk("i_writes_drained", 32'(exp_i.size()), 0);
        chk("d_writes_drained", 32'(exp_d.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic load_case1();
        iw.delete();
        dw.delete();
        iw.push_back(32'h0050_0293);
        iw.push_back(32'h0010_0313);
        dw.push_back(32'hDEAD_BEEF);
    endtask

    task automatic load_random(input int ni, input int nd);
        iw.delete();
        dw.delete();
        for (int k = 0; k < ni; k++) iw.push_back($urandom);
        for (int k = 0; k < nd; k++) dw.push_back($urandom);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ni;
        int nd;
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_dat   = 8'd0;
        rst         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed image, back-to-back then with valid gaps
        load_case1();
        run_session(32'd2, 32'd1, 0, -1, -1);
        run_session(32'd2, 32'd1, 3, -1, -1);

        // Empty image
        run_session(32'd0, 32'd0, 0, -1, -1);

        // Oversized header, then the next start (from ERROR) must clear err
        run_session(32'd257, 32'd0, 0, -1, -1);

        // Start pulse mid LOAD_I is ignored
        load_case1();
        run_session(32'd2, 32'd1, 0, 9, -1);

        // Reset after two bytes of the first word, then reload
        run_session(32'd2, 32'd1, 0, -1, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values();
        chk("partial_no_i_write", 32'(exp_i.size()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_session(32'd2, 32'd1, 0, -1, -1);

        // Random small images
        for (int r = 0; r < 8; r++) begin
            ni = $urandom_range(6, 0);
            nd = $urandom_range(6, 0);
            load_random(ni, nd);
            run_session(32'(ni), 32'(nd), $urandom_range(3, 0), -1, -1);
        end

        // Data count just over the limit, and a huge instruction count
        run_session(32'd3, 32'd257, 0, -1, -1);
        run_session(32'hFFFF_FFFF, 32'd1, 1, -1, -1);

        // Largest legal image: last address 0x3FC in both memories
        load_random(256, 256);
        run_session(32'd256, 32'd256, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
